// File: rtl/ling_pkg.sv
// Shared constants, types and helpers for the Ling/Knowles pipelined subtractor.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ling_pkg;

    // Prefix levels evaluated in the second register stage; the rest go to the third.
    localparam int S2_LEVELS = 3;

    // Scalar part of the first-stage payload. The WIDTH-wide p/g vectors are
    // added around it in the top, where WIDTH is known.
    typedef struct packed {
        logic cin;
        logic a_msb;
        logic b_msb;
    } stage_ctl_t;

    // Number of prefix levels needed to span n bits (ceil(log2 n)).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ling_prefix_level.sv
// One level of the Ling prefix tree: combines (H, I) pairs of span SPAN into span 2*SPAN.
// Latency: combinational.
// Backpressure: not applicable.
module ling_prefix_level #(
    parameter int WIDTH = 20,
    parameter int SPAN  = 1
) (
    input  logic [WIDTH-1:0] h_in,
    input  logic [WIDTH-1:0] i_in,
    output logic [WIDTH-1:0] h_out,
    output logic [WIDTH-1:0] i_out
);

    for (genvar j = 0; j < WIDTH; j++) begin : g_bit
        if (j < SPAN) begin : g_pass
            // Group already reaches the carry-in; nothing left to combine.
            assign h_out[j] = h_in[j];
            assign i_out[j] = i_in[j];
        end else if (j < 2 * SPAN) begin : g_grey
            // Lower group is complete, so only H is needed and the group closes.
            assign h_out[j] = h_in[j] | (i_in[j] & h_in[j-SPAN]);
            assign i_out[j] = 1'b0;
        end else begin : g_black
            assign h_out[j] = h_in[j] | (i_in[j] & h_in[j-SPAN]);
            assign i_out[j] = i_in[j] & i_in[j-SPAN];
        end
    end

endmodule

// File: rtl/ling_knowles_sub_pipe.sv
// Pipelined subtractor diff = a - b - bin using a Ling parallel-prefix carry tree.
// Latency: 3 cycles (accept at edge k, result valid after edge k+2), 1 beat/cycle.
// Backpressure: full valid/ready; stages load when empty or draining, bubbles collapse.
module ling_knowles_sub_pipe
    import ling_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int LEVELS = clog2(WIDTH);
    localparam int N2     = (LEVELS < S2_LEVELS) ? LEVELS : S2_LEVELS;
    localparam int N3     = LEVELS - N2;

    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        stage_ctl_t       ctl;
    } s1_pay_t;

    typedef struct packed {
        logic [WIDTH-1:0] h;
        logic [WIDTH-1:0] i;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] x;
        stage_ctl_t       ctl;
    } s2_pay_t;

    // ---------------- handshake ----------------
    logic v1, v2, v3;
    logic ld1, ld2, ld3;

    assign ld3       = ~v3 | out_ready;
    assign ld2       = ~v2 | ld3;
    assign ld1       = ~v1 | ld2;
    assign in_ready  = ld1;
    assign out_valid = v3;

    // Stage valid bits advance whenever the receiving stage can load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (ld1) v1 <= in_valid;
            if (ld2) v2 <= v1;
            if (ld3) v3 <= v2;
        end
    end

    // ---------------- S1: inverted-subtrahend generate/propagate ----------------
    s1_pay_t s1_nxt, s1_q;

    assign s1_nxt.p         = a | ~b;
    assign s1_nxt.g         = a & ~b;
    assign s1_nxt.ctl.cin   = ~bin;
    assign s1_nxt.ctl.a_msb = a[WIDTH-1];
    assign s1_nxt.ctl.b_msb = b[WIDTH-1];

    // Capture operands only for real beats so idle cycles do not disturb data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) s1_q <= '0;
        else if (ld1 && in_valid) s1_q <= s1_nxt;
    end

    // ---------------- S2: reduced Ling cell plus low prefix levels ----------------
    logic [WIDTH-1:0] hs2 [N2+1];
    logic [WIDTH-1:0] is2 [N2+1];

    // Carry-in acts as a generate one position below bit 0; I[j] is the
    // propagate of the bit beneath j, and bit 0 has nothing beneath it.
    assign hs2[0] = s1_q.g | {s1_q.g[WIDTH-2:0], s1_q.ctl.cin};
    assign is2[0] = {s1_q.p[WIDTH-2:0], 1'b0};

    for (genvar k = 0; k < N2; k++) begin : g_s2_lvl
        ling_prefix_level #(.WIDTH(WIDTH), .SPAN(1 << k)) u_lvl (
            .h_in  (hs2[k]),
            .i_in  (is2[k]),
            .h_out (hs2[k+1]),
            .i_out (is2[k+1])
        );
    end

    s2_pay_t s2_nxt, s2_q;

    assign s2_nxt.h   = hs2[N2];
    assign s2_nxt.i   = is2[N2];
    assign s2_nxt.p   = s1_q.p;
    assign s2_nxt.x   = s1_q.p ^ s1_q.g;
    assign s2_nxt.ctl = s1_q.ctl;

    // Partial prefix results move on when S1 holds a beat and S2 can load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) s2_q <= '0;
        else if (ld2 && v1) s2_q <= s2_nxt;
    end

    // ---------------- S3: upper prefix levels and sum recovery ----------------
    logic [WIDTH-1:0] hs3 [N3+1];
    logic [WIDTH-1:0] is3 [N3+1];

    assign hs3[0] = s2_q.h;
    assign is3[0] = s2_q.i;

    for (genvar k = 0; k < N3; k++) begin : g_s3_lvl
        ling_prefix_level #(.WIDTH(WIDTH), .SPAN(1 << (N2 + k))) u_lvl (
            .h_in  (hs3[k]),
            .i_in  (is3[k]),
            .h_out (hs3[k+1]),
            .i_out (is3[k+1])
        );
    end

    logic [WIDTH-1:0] hf;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // A real carry out of bit j is the Ling pseudo-carry gated by that bit's propagate.
    assign hf    = hs3[N3];
    assign carry = {s2_q.p[WIDTH-2:0] & hf[WIDTH-2:0], s2_q.ctl.cin};
    assign sum   = s2_q.x ^ carry;
    assign cout  = s2_q.p[WIDTH-1] & hf[WIDTH-1];

    // Result registers change only when a new beat lands, so they hold during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (ld3 && v2) begin
            diff <= sum;
            bout <= ~cout;
            ovf  <= (s2_q.ctl.a_msb != s2_q.ctl.b_msb) && (sum[WIDTH-1] != s2_q.ctl.a_msb);
            zero <= (sum == '0);
        end
    end

endmodule

// File: tb/tb_ling_knowles_sub_pipe.sv
// Self-checking bench for the pipelined Ling subtractor.
// Latency: checks 3-cycle latency and 1 beat/cycle throughput.
// Backpressure: exercises stalls, full pipeline, random valid/ready and async reset.
module tb_ling_knowles_sub_pipe;

    localparam int W = 20;
    localparam int N = 10000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    always #5 clk = ~clk;

    ling_knowles_sub_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        logic         z;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        logic         z;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t sb [$];

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        res_t   r;
        longint ua, ub, sa, sbv, sd, full, lim;
        lim  = longint'(1) <<< (W - 1);
        ua   = longint'(ma);
        ub   = longint'(mb);
        full = ua - ub - longint'(mbin);
        r.d  = full[W-1:0];
        r.bo = (ua < ub + longint'(mbin));
        sa   = ma[W-1] ? ua - 2 * lim : ua;
        sbv  = mb[W-1] ? ub - 2 * lim : ub;
        sd   = sa - sbv - longint'(mbin);
        r.ov = (sd >= lim) || (sd < -lim);
        r.z  = (r.d == '0);
        return r;
    endfunction

    function automatic res_t dut_res();
        res_t r;
        r.d  = diff;
        r.bo = bout;
        r.ov = ovf;
        r.z  = zero;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge, then let combinational outputs settle.
    task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ibin, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        bin       = ibin;
        out_ready = ordy;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl [8];
        logic [W-1:0] bpa [5];
        logic [W-1:0] bpb [5];
        logic         bpbin [5];
        int           lat, idx, got, sent, rcvd, cyc, extra;
        logic         iv, ordy, rbin;
        logic [W-1:0] ra, rb;

        tbl[0] = '{20'h00005, 20'h00003, 1'b0, 20'h00002, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{20'h00000, 20'h00001, 1'b0, 20'hFFFFF, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{20'h00004, 20'h00003, 1'b1, 20'h00000, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{20'h80000, 20'h00001, 1'b0, 20'h7FFFF, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{20'h7FFFF, 20'hFFFFF, 1'b0, 20'h80000, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{20'h12345, 20'hFFFFF, 1'b1, 20'h12345, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{20'h80000, 20'h7FFFF, 1'b1, 20'h00000, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{20'h00000, 20'h00000, 1'b1, 20'hFFFFF, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 5; i++) begin
            bpa[i]   = W'($urandom);
            bpb[i]   = W'($urandom);
            bpbin[i] = 1'($urandom_range(0, 1));
        end

        // ---- reset state ----
        repeat (2) @(negedge clk);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset diff", diff, 0);
        check("reset bout", bout, 0);
        check("reset ovf", ovf, 0);
        check("reset zero", zero, 0);
        rst = 1'b0;
        step(1'b0, '0, '0, 1'b0, 1'b1);
        check("post-reset in_ready", in_ready, 1);

        // ---- directed vectors, one beat at a time ----
        for (int t = 0; t < 8; t++) begin
            step(1'b1, tbl[t].a, tbl[t].b, tbl[t].bin, 1'b1);
            check($sformatf("vec%0d in_ready", t), in_ready, 1);
            lat = 0;
            while (lat < 10) begin
                step(1'b0, '0, '0, 1'b0, 1'b1);
                lat++;
                if (out_valid) break;
            end
            check($sformatf("vec%0d latency", t), lat, 3);
            check($sformatf("vec%0d diff", t), diff, tbl[t].d);
            check($sformatf("vec%0d bout", t), bout, tbl[t].bo);
            check($sformatf("vec%0d ovf", t), ovf, tbl[t].ov);
            check($sformatf("vec%0d zero", t), zero, tbl[t].z);
        end

        // ---- backpressure: stall with 5 beats offered ----
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            step(idx < 5, idx < 5 ? bpa[idx] : '0, idx < 5 ? bpb[idx] : '0,
                 idx < 5 ? bpbin[idx] : 1'b0, 1'b0);
            if (in_valid && in_ready) idx++;
            if (out_valid) check("bp stall result", dut_res(), model(bpa[0], bpb[0], bpbin[0]));
        end
        check("bp accepted while stalled", idx, 3);
        check("bp in_ready when full", in_ready, 0);
        check("bp out_valid when full", out_valid, 1);
        got = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            step(idx < 5, idx < 5 ? bpa[idx] : '0, idx < 5 ? bpb[idx] : '0,
                 idx < 5 ? bpbin[idx] : 1'b0, 1'b1);
            if (c == 0) check("bp same-cycle in_ready", in_ready, 1);
            if (in_valid && in_ready) idx++;
            if (out_valid) begin
                check($sformatf("bp order beat%0d", got), dut_res(), model(bpa[got], bpb[got], bpbin[got]));
                got++;
            end
        end
        check("bp beats emitted", got, 5);
        check("bp beats accepted", idx, 5);

        // ---- random traffic against the reference model ----
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while ((sent < N || sb.size() > 0) && cyc < 80000) begin
            iv   = (sent < N) && ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: rb = '1;
                1: rb = ra;
                2: ra = '0;
                3: ra = {1'b1, {(W-1){1'b0}}};
                default: ;
            endcase
            step(iv, ra, rb, rbin, ordy);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("rnd spurious out_valid", out_valid, 0);
                end else begin
                    check("rnd result", dut_res(), sb[0]);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        rcvd++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(ra, rb, rbin));
                sent++;
            end
            cyc++;
        end
        check("rnd beats sent", sent, N);
        check("rnd beats received", rcvd, N);
        check("rnd leftover", sb.size(), 0);

        // ---- async reset with beats in flight ----
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b1, 20'h11111, 20'h00001, 1'b0, 1'b0);
        step(1'b1, 20'h22222, 20'h00002, 1'b0, 1'b0);
        lat = 0;
        while (lat < 10) begin
            step(1'b0, '0, '0, 1'b0, 1'b0);
            lat++;
            if (out_valid) break;
        end
        check("rst pre out_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst async out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 20'h33333, 20'h00003, 1'b1, 1'b1);
        check("rst release in_ready", in_ready, 1);
        lat = 0;
        while (lat < 10) begin
            step(1'b0, '0, '0, 1'b0, 1'b1);
            lat++;
            if (out_valid) break;
        end
        check("rst first beat latency", lat, 3);
        check("rst first beat result", dut_res(), model(20'h33333, 20'h00003, 1'b1));
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1);
            if (out_valid) extra++;
        end
        check("rst no stale beats", extra, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ling_knowles_sub_pipe.md
Name: ling_knowles_sub_pipe

Overview:
Pipelined WIDTH-bit two's-complement subtractor: diff = a - b - bin. Runs the adder datapath in reverse: a + ~b + ~bin through a Ling/Knowles parallel-prefix carry network split over three register stages. Sits between the operand scheduler and the result writeback. Uses valid/ready handshakes on both sides and supports full backpressure with one result per cycle.

Parameters:
WIDTH, 20, operand and result width in bits (>= 4)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept operand beat this cycle
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow in
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result this cycle
diff  output  WIDTH  (a - b - bin) mod 2^WIDTH
bout  output  1  borrow out; 1 iff a < b + bin (unsigned)
ovf  output  1  signed overflow of a - b - bin
zero  output  1  diff == 0

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0. out_valid=0. diff, bout, ovf, zero = 0. in_ready=1 from the first cycle after release.
- Datapath: p = a | ~b, g = a & ~b, carry-in = ~bin. Ling pseudo-carries use the same reduced and full prefix cells as the adder. diff = sum bits. bout = ~carry-out. ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]). zero is computed in S3 from the final sum.
- Stage S1 registers p, g, carry-in, and the operand MSBs for ovf. Stage S2 registers prefix levels spanning 1, 2 and 4 bits. Stage S3 registers the remaining levels (8, 16, ...; ceil(log2 WIDTH) total) plus the post-computation. diff, bout, ovf and zero are driven straight from S3 registers.
- Latency: a beat accepted at rising edge k (in_valid & in_ready) appears with out_valid=1 in the cycle after edge k+2, provided no stall occurs. Throughput is 1 beat/cycle.
- Handshake:
  - Stage i loads when it is empty or its content moves to stage i+1 in the same cycle. S3 moves when out_valid & out_ready.
  - in_ready = S1 can load. This is combinational from out_ready through the stage valids; no other combinational path exists.
  - Bubbles collapse: an empty stage loads even while downstream stalls.
- Result stability: while out_valid & ~out_ready, diff, bout, ovf and zero hold stable. Results are never dropped or duplicated, and order is preserved.
- Full: with all three stages valid and out_ready=0, in_ready=0. If out_ready rises in that state, in_ready=1 in the same cycle and the pipeline shifts with no lost cycle.
- Empty: out_valid=0. Data outputs hold their last value and are don't-care for the bench.
- Simultaneous accept and emit with all stages full: S3 emits, S1 loads the new beat, and occupancy stays at 3.
- in_valid=0 with a stage loading: that stage's valid clears. Its data registers may hold stale data.
- Reset mid-operation: all in-flight beats are discarded and out_valid drops immediately (async). No beat entered before reset is ever emitted afterwards.
- Width rules: all arithmetic is modulo 2^WIDTH. bin=1 with b = 2^WIDTH-1 is legal and gives bout=1 unless a = b+bin is impossible, in which case bout=1 always.

Decomposition:
- Shared package ling_pkg:
  - prefix level count function clog2(WIDTH)
  - stage-split constant S2_LEVELS=3
  - struct type for stage payload {p, g, cin, a_msb, b_msb}
- One sub-module, ling_prefix_level. It is combinational and parameterised by WIDTH and span. Given H/I vectors for span s, it produces H/I for span 2s using black/grey and reduced cells. It is instantiated per level in S2 and S3 so the prefix network is not hand-unrolled.

Test Plan:
1. a=0x00005, b=0x00003, bin=0, out_ready=1 -> 3 cycles later diff=0x00002, bout=0, ovf=0, zero=0.
2. a=0x00000, b=0x00001, bin=0 -> diff=0xFFFFF, bout=1, ovf=0. Then a=0x00004, b=0x00003, bin=1 -> diff=0x00000, zero=1, bout=0.
3. a=0x80000, b=0x00001, bin=0 -> diff=0x7FFFF, ovf=1, bout=0. Then a=0x7FFFF, b=0xFFFFF -> diff=0x80000, ovf=1, bout=1.
4. Backpressure: hold out_ready=0 and stream 5 beats with in_valid=1 -> exactly 3 accepted and in_ready=0 afterwards. Raise out_ready -> 5 results emerge in order, with data stable during the stall cycles.
5. Random 10k beats with random in_valid/out_ready toggling -> scoreboard matches the reference model (a - b - bin, bout, ovf, zero) with no drops or duplicates.
6. Assert rst with 2 beats in flight -> out_valid=0 immediately. After release, the first result corresponds to the first post-reset beat only.
